// File: rtl/scoreboard_dispatch.sv
// scoreboard_dispatch: in-order dispatch FIFO presenting decoded instructions to the scoreboard issue port.
// Optional stall watchdog built only when SB_DISPATCH_WDOG_EN is defined.
module scoreboard_dispatch #(
  parameter int DEPTH    = 8,
  parameter int REG_BITS = 5,
  parameter int CNT_W    = 16,
  parameter int WDOG_LIM = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2:0]                in_op,
  input  logic [REG_BITS-1:0]       in_fi,
  input  logic [REG_BITS-1:0]       in_fj,
  input  logic [REG_BITS-1:0]       in_fk,
  input  logic                      flush,
  input  logic                      pause,
  input  logic                      stall,
  output logic                      inst_valid,
  output logic [2:0]                inst_op,
  output logic [REG_BITS-1:0]       inst_fi,
  output logic [REG_BITS-1:0]       inst_fj,
  output logic [REG_BITS-1:0]       inst_fk,
  output logic [1:0]                inst_fu_type,
  output logic [$clog2(DEPTH):0]    count,
  output logic [1:0]                state,
  output logic [CNT_W-1:0]          issue_count,
  output logic [CNT_W-1:0]          stall_cycles,
  output logic                      deadlock
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STALL = 2'd2, PAUSE = 2'd3} state_t;
  state_t state_q, state_d;
  logic [2:0]          op_mem [DEPTH];
  logic [REG_BITS-1:0] fi_mem [DEPTH];
  logic [REG_BITS-1:0] fj_mem [DEPTH];
  logic [REG_BITS-1:0] fk_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_d;
  logic push, pop;
  assign in_ready = count != CW'(DEPTH);
  assign push     = in_valid && in_ready && !flush;
  assign pop      = inst_valid && !stall && !flush;
  assign count_d  = flush ? '0 : count + CW'(push) - CW'(pop);
  assign state    = state_q;
  assign inst_op  = op_mem[rd_ptr];
  assign inst_fi  = fi_mem[rd_ptr];
  assign inst_fj  = fj_mem[rd_ptr];
  assign inst_fk  = fk_mem[rd_ptr];
  assign inst_fu_type = inst_op == 3'd5 ? 2'd2 : inst_op == 3'd6 ? 2'd3 : 2'd0;
  // Storage carries no reset; entries are qualified by count.
  always_ff @(posedge clk)
    if (push) begin
      op_mem[wr_ptr] <= in_op;
      fi_mem[wr_ptr] <= in_fi;
      fj_mem[wr_ptr] <= in_fj;
      fk_mem[wr_ptr] <= in_fk;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      issue_count  <= '0;
      stall_cycles <= '0;
    end else begin
      wr_ptr <= flush ? '0 : wr_ptr + AW'(push);
      rd_ptr <= flush ? '0 : rd_ptr + AW'(pop);
      count  <= count_d;
      if (pop) issue_count <= issue_count + 1'b1;
      if (inst_valid && stall && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = flush ? IDLE :
              pause ? PAUSE :
              count_d == '0 ? IDLE :
              (inst_valid && stall) ? STALL : RUN;
  always_comb
    inst_valid = count != '0 && !pause && state_q != PAUSE;
`ifdef SB_DISPATCH_WDOG_EN
  localparam int WW = $clog2(WDOG_LIM + 1);
  logic [WW-1:0] wdog;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wdog     <= '0;
      deadlock <= 1'b0;
    end else if (flush) begin
      wdog     <= '0;
      deadlock <= 1'b0;
    end else if (pop || !inst_valid) begin
      wdog <= '0;
    end else begin
      if (wdog != WW'(WDOG_LIM)) wdog <= wdog + 1'b1;
      if (wdog == WW'(WDOG_LIM - 1)) deadlock <= 1'b1;
    end
`else
  assign deadlock = 1'b0;
`endif
endmodule

// File: tb/tb_scoreboard_dispatch.sv
// tb_scoreboard_dispatch: directed self-checking bench for scoreboard_dispatch.
module tb_scoreboard_dispatch;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, flush = 0, pause = 0, stall = 0;
  logic [2:0] in_op = 0, inst_op;
  logic [4:0] in_fi = 0, in_fj = 0, in_fk = 0, inst_fi, inst_fj, inst_fk;
  logic inst_valid, deadlock;
  logic [1:0] inst_fu_type, state;
  logic [3:0] count;
  logic [15:0] issue_count, stall_cycles;
  int checks = 0, errors = 0;

  scoreboard_dispatch dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_fi(in_fi), .in_fj(in_fj), .in_fk(in_fk),
    .flush(flush), .pause(pause), .stall(stall), .inst_valid(inst_valid),
    .inst_op(inst_op), .inst_fi(inst_fi), .inst_fj(inst_fj), .inst_fk(inst_fk),
    .inst_fu_type(inst_fu_type), .count(count), .state(state),
    .issue_count(issue_count), .stall_cycles(stall_cycles), .deadlock(deadlock)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] op, input logic [4:0] fi);
    in_valid = 1; in_op = op; in_fi = fi; in_fj = fi + 5'd1; in_fk = fi + 5'd2;
    step();
    in_valid = 0;
  endtask

  initial begin
    #1;
    chk("rst_count", count, 0);
    chk("rst_state", state, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_issue", issue_count, 0);
    chk("rst_stallc", stall_cycles, 0);
    chk("rst_dead", deadlock, 0);
    step(); step();
    rst_n = 1;
    // back-to-back ALU, MUL, DIV with no stall
    push(3'd0, 5'd1);
    chk("t1_valid", inst_valid, 1);
    chk("t1_state", state, 1);
    chk("t1_fu0", inst_fu_type, 0);
    chk("t1_fj", inst_fj, 2);
    push(3'd5, 5'd2);
    chk("t1_fu2", inst_fu_type, 2);
    chk("t1_count", count, 1);
    push(3'd6, 5'd3);
    chk("t1_fu3", inst_fu_type, 3);
    chk("t1_op", inst_op, 6);
    step();
    chk("t1_issue", issue_count, 3);
    chk("t1_cnt0", count, 0);
    chk("t1_idle", state, 0);
    chk("t1_novalid", inst_valid, 0);
    // fill while paused, hold 9th, then drain across pointer wrap
    pause = 1;
    for (int i = 0; i < 8; i++) push(3'(i), 5'(10 + i));
    chk("t2_full", count, 8);
    chk("t2_ready0", in_ready, 0);
    chk("t2_pause", state, 3);
    in_valid = 1; in_op = 3'd1; in_fi = 5'd30; in_fj = 0; in_fk = 0;
    step();
    chk("t2_held", count, 8);
    pause = 0;
    step();
    chk("t2_run", state, 1);
    chk("t2_valid", inst_valid, 1);
    chk("t2_head", inst_fi, 10);
    chk("t2_ready_pop", in_ready, 0);
    step();
    chk("t2_cnt7", count, 7);
    chk("t2_ready1", in_ready, 1);
    chk("t2_head11", inst_fi, 11);
    step();
    in_valid = 0;
    chk("t2_cnt7b", count, 7);
    for (int k = 12; k < 18; k++) begin
      chk("t2_order", inst_fi, k);
      step();
    end
    chk("t2_last", inst_fi, 30);
    step();
    chk("t2_empty", count, 0);
    chk("t2_issue", issue_count, 12);
    // stalled head must stay put
    stall = 1;
    push(3'd2, 5'd7);
    for (int i = 0; i < 5; i++) step();
    chk("t3_fi", inst_fi, 7);
    chk("t3_state", state, 2);
    chk("t3_stallc", stall_cycles, 5);
    chk("t3_nopop", issue_count, 12);
    stall = 0;
    step();
    chk("t3_pop", issue_count, 13);
    chk("t3_cnt", count, 0);
    chk("t3_idle", state, 0);
    // simultaneous push/pop at count 4, then flush with a pending push
    pause = 1;
    for (int i = 1; i <= 4; i++) push(3'd0, 5'(i));
    pause = 0;
    step();
    chk("t4_cnt4", count, 4);
    push(3'd0, 5'd5);
    chk("t4_pp", count, 4);
    chk("t4_issue", issue_count, 14);
    chk("t4_head", inst_fi, 2);
    flush = 1; in_valid = 1; in_fi = 5'd25;
    step();
    flush = 0; in_valid = 0;
    chk("t4_fcnt", count, 0);
    chk("t4_fidle", state, 0);
    chk("t4_fvalid", inst_valid, 0);
    chk("t4_fissue", issue_count, 14);
    step();
    chk("t4_discard", count, 0);
    push(3'd0, 5'd9);
    chk("t4_after", inst_fi, 9);
    step();
    chk("t4_issue15", issue_count, 15);
    // pause blocks dispatch and releases the same head
    pause = 1;
    push(3'd5, 5'd20);
    push(3'd6, 5'd21);
    chk("t5_cnt", count, 2);
    chk("t5_state", state, 3);
    chk("t5_valid", inst_valid, 0);
    step(); step();
    chk("t5_nopop", count, 2);
    pause = 0;
    step();
    chk("t5_head", inst_fi, 20);
    chk("t5_fu", inst_fu_type, 2);
    chk("t5_rvalid", inst_valid, 1);
    step(); step();
    chk("t5_issue", issue_count, 17);
    // long stall for the watchdog
    stall = 1;
    push(3'd0, 5'd3);
    for (int i = 0; i < 63; i++) step();
    chk("t6_dead63", deadlock, 0);
    step();
`ifdef SB_DISPATCH_WDOG_EN
    chk("t6_dead64", deadlock, 1);
    for (int i = 0; i < 5; i++) step();
    chk("t6_sticky", deadlock, 1);
`else
    chk("t6_dead64", deadlock, 0);
    for (int i = 0; i < 5; i++) step();
    chk("t6_sticky", deadlock, 0);
`endif
    chk("t6_stallc", stall_cycles, 74);
    flush = 1;
    step();
    flush = 0; stall = 0;
    chk("t6_clear", deadlock, 0);
    chk("t6_cnt", count, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
